// File: rtl/shift_add_multiplier.sv
// Purpose : radix-2 shift-and-add unsigned multiplier, BIT_WIDTH x BIT_WIDTH -> 2*BIT_WIDTH,
//           built around a single BIT_WIDTH-bit ripple-carry adder.
// Latency : BIT_WIDTH+1 edges from accepting start to done_o; accepts a new start in IDLE or DONE.
// Backpressure: none; start is ignored while busy_o is high, and the result is held only until the next accept.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start, a, b     request and operands (a = multiplicand, b = multiplier), sampled on the accepting edge
//   busy_o          high while iterating
//   done_o          one-cycle result strobe
//   product_o       {hi, lo} accumulator; final product while done_o, held until the next accept

// Parameterised ripple-carry adder: one full adder per bit, carry chained LSB to MSB.
module ripple_carry_adder_param #(
    parameter int BIT_WIDTH = 32
) (
    input  logic [BIT_WIDTH-1:0] a_i,
    input  logic [BIT_WIDTH-1:0] b_i,
    input  logic                 cin_i,
    output logic [BIT_WIDTH-1:0] sum_o,
    output logic                 cout_o
);
    logic [BIT_WIDTH:0] carry;

    assign carry[0] = cin_i;

    for (genvar gi = 0; gi < BIT_WIDTH; gi++) begin : g_fa
        assign sum_o[gi]      = a_i[gi] ^ b_i[gi] ^ carry[gi];
        assign carry[gi + 1]  = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
    end

    assign cout_o = carry[BIT_WIDTH];
endmodule

module shift_add_multiplier #(
    parameter int BIT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [BIT_WIDTH-1:0]   a,
    input  logic [BIT_WIDTH-1:0]   b,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [2*BIT_WIDTH-1:0] product_o
);
    localparam int CW = $clog2(BIT_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [BIT_WIDTH-1:0] mcand_q, mcand_d;
    logic [BIT_WIDTH-1:0] hi_q, hi_d;
    logic [BIT_WIDTH-1:0] lo_q, lo_d;
    logic [CW-1:0]        count_q, count_d;

    logic [BIT_WIDTH-1:0] add_sum;
    logic                 add_cout;
    logic [BIT_WIDTH-1:0] part_s;
    logic                 part_c;
    logic                 accept;
    logic                 last_iter;

    // A request is taken only when not iterating.
    assign accept    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // count_q holds the number of RUN edges already taken; this edge is the final one.
    assign last_iter = (count_q == CW'(BIT_WIDTH - 1));

    ripple_carry_adder_param #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_adder (
        .a_i    (hi_q),
        .b_i    (mcand_q),
        .cin_i  (1'b0),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // Add the multiplicand only when the current multiplier bit is set.
    // The carry-out becomes the new MSB of hi, so the 2N-bit accumulator stays exact.
    always_comb begin
        part_s = hi_q;
        part_c = 1'b0;
        if (lo_q[0]) begin
            part_s = add_sum;
            part_c = add_cout;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last_iter) state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs decoded from registered state only
    always_comb begin
        busy_o = (state_q == ST_RUN);
        done_o = (state_q == ST_DONE);
    end

    // Datapath next-state
    always_comb begin
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        count_d = count_q;
        if (accept) begin
            mcand_d = a;
            hi_d    = '0;
            lo_d    = b;
            count_d = '0;
        end else if (state_q == ST_RUN) begin
            // Shift {c, s, lo} right by one: multiplier bits leave lo as product bits enter.
            hi_d    = {part_c, part_s[BIT_WIDTH-1:1]};
            lo_d    = {part_s[0], lo_q[BIT_WIDTH-1:1]};
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            count_q <= '0;
        end else begin
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            count_q <= count_d;
        end
    end

    assign product_o = {hi_q, lo_q};
endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;
    logic        clk;
    logic        rst_n;

    logic        start8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] prod8;

    logic        start32;
    logic [31:0] a32, b32;
    logic        busy32, done32;
    logic [63:0] prod32;

    int n_assert;
    int n_fail;

    shift_add_multiplier #(.BIT_WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start8),
        .a         (a8),
        .b         (b8),
        .busy_o    (busy8),
        .done_o    (done8),
        .product_o (prod8)
    );

    shift_add_multiplier #(.BIT_WIDTH(32)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start32),
        .a         (a32),
        .b         (b32),
        .busy_o    (busy32),
        .done_o    (done32),
        .product_o (prod32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and settle, so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int w, input logic s, input logic [31:0] av, input logic [31:0] bv);
        if (w == 8) begin
            start8 = s; a8 = av[7:0]; b8 = bv[7:0];
        end else begin
            start32 = s; a32 = av; b32 = bv;
        end
    endtask

    function automatic logic [63:0] get_busy(input int w);
        return (w == 8) ? 64'(busy8) : 64'(busy32);
    endfunction

    function automatic logic [63:0] get_done(input int w);
        return (w == 8) ? 64'(done8) : 64'(done32);
    endfunction

    function automatic logic [63:0] get_prod(input int w);
        return (w == 8) ? 64'(prod8) : prod32;
    endfunction

    // Reference: plain integer product of the operands truncated to width w.
    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] av, input logic [31:0] bv);
        logic [63:0] x, y;
        x = (w == 8) ? 64'(av[7:0]) : 64'(av);
        y = (w == 8) ? 64'(bv[7:0]) : 64'(bv);
        return x * y;
    endfunction

    // One full operation with a single-cycle start. With noisy set, start and the
    // operands are scrambled throughout RUN to confirm they are ignored there.
    task automatic do_op(input int w, input logic [31:0] av, input logic [31:0] bv, input bit noisy, input string tag);
        logic [63:0] exp;
        exp = ref_mul(w, av, bv);
        set_in(w, 1'b1, av, bv);
        tick();
        set_in(w, 1'b0, av, bv);
        for (int i = 0; i < w; i++) begin
            chk({tag, "_busy"}, get_busy(w), 64'd1);
            chk({tag, "_nodone"}, get_done(w), 64'd0);
            if (noisy) set_in(w, 1'($urandom_range(0, 1)), $urandom, $urandom);
            tick();
        end
        chk({tag, "_done"}, get_done(w), 64'd1);
        chk({tag, "_busy_off"}, get_busy(w), 64'd0);
        chk({tag, "_prod"}, get_prod(w), exp);
        set_in(w, 1'b0, $urandom, $urandom);
        tick();
        chk({tag, "_done_off"}, get_done(w), 64'd0);
        chk({tag, "_idle_busy"}, get_busy(w), 64'd0);
        chk({tag, "_held"}, get_prod(w), exp);
    endtask

    initial begin
        logic [31:0] ra, rb;
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        set_in(8, 1'b0, 32'd0, 32'd0);
        set_in(32, 1'b0, 32'd0, 32'd0);

        // Reset
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_busy8", 64'(busy8), 64'd0);
            chk("rst_done8", 64'(done8), 64'd0);
            chk("rst_prod8", 64'(prod8), 64'd0);
            chk("rst_busy32", 64'(busy32), 64'd0);
            chk("rst_done32", 64'(done32), 64'd0);
            chk("rst_prod32", prod32, 64'd0);
        end

        // Directed corners
        do_op(8, 32'h03, 32'h05, 1'b0, "w8_3x5");
        chk("w8_3x5_const", 64'(prod8), 64'h000F);
        do_op(8, 32'hFF, 32'hFF, 1'b0, "w8_ffxff");
        chk("w8_ffxff_const", 64'(prod8), 64'hFE01);
        do_op(32, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "w32_max");
        chk("w32_max_const", prod32, 64'hFFFFFFFE00000001);
        do_op(32, 32'h0, 32'hDEADBEEF, 1'b0, "w32_zero");
        chk("w32_zero_const", prod32, 64'h0);

        // Start held high: back-to-back, done every 9 cycles, new operands taken at done
        set_in(8, 1'b1, 32'h12, 32'h34);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("b2b_busy1", 64'(busy8), 64'd1);
            tick();
        end
        chk("b2b_done1", 64'(done8), 64'd1);
        chk("b2b_prod1", 64'(prod8), 64'h03A8);
        set_in(8, 1'b1, 32'h02, 32'h07);
        tick();
        chk("b2b_accept_prod", 64'(prod8), 64'h0007);
        for (int i = 0; i < 8; i++) begin
            chk("b2b_busy2", 64'(busy8), 64'd1);
            chk("b2b_nodone2", 64'(done8), 64'd0);
            tick();
        end
        chk("b2b_done2", 64'(done8), 64'd1);
        chk("b2b_prod2", 64'(prod8), 64'h000E);
        set_in(8, 1'b0, 32'h0, 32'h0);
        tick();
        chk("b2b_done_off", 64'(done8), 64'd0);

        // Start pulses and operand churn during RUN ignored
        do_op(8, 32'h9C, 32'h5B, 1'b1, "w8_noisy");
        do_op(32, 32'h89ABCDEF, 32'h13579BDF, 1'b1, "w32_noisy");

        // Randomised operations against the arithmetic reference
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            do_op(8, ra, rb, 1'($urandom_range(0, 1)), "w8_rand");
        end
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            do_op(32, ra, rb, 1'b0, "w32_rand");
        end

        // Reset mid-operation: asynchronous clear
        set_in(8, 1'b1, 32'hC3, 32'hA5);
        set_in(32, 1'b1, 32'h12345678, 32'h9ABCDEF0);
        tick();
        set_in(8, 1'b0, 32'h0, 32'h0);
        set_in(32, 1'b0, 32'h0, 32'h0);
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy8", 64'(busy8), 64'd0);
        chk("midrst_done8", 64'(done8), 64'd0);
        chk("midrst_prod8", 64'(prod8), 64'd0);
        chk("midrst_busy32", 64'(busy32), 64'd0);
        chk("midrst_prod32", prod32, 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("postrst_idle", 64'(busy8), 64'd0);
        do_op(8, 32'h0A, 32'h0B, 1'b0, "postrst");
        chk("postrst_const", 64'(prod8), 64'h006E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
